// File: rtl/trivium_driver_if.sv
// Core-side bus between the Trivium driver and the keystream core.
// The master side is the driver; the slave side is the core.
interface trivium_driver_if;
  logic core_dat_o;      // serial key/IV bit or plaintext bit toward the core
  logic core_get_dat_o;  // core consumes/produces a bit this cycle
  logic core_ld_keys_o;  // marks the final IV bit of the load sequence
  logic core_dat_i;      // cipher bit returned by the core, same cycle
  logic core_ready_i;    // core finished its warm-up rounds

  modport master (
    output core_dat_o,
    output core_get_dat_o,
    output core_ld_keys_o,
    input  core_dat_i,
    input  core_ready_i
  );

  modport slave (
    input  core_dat_o,
    input  core_get_dat_o,
    input  core_ld_keys_o,
    output core_dat_i,
    output core_ready_i
  );
endinterface

// File: rtl/trivium_driver.sv
// Trivium driver: serialises an 80-bit key and 80-bit IV into the core,
// waits for the core to finish warm-up (with timeout), then streams
// plaintext bytes LSB first through the core and reassembles cipher bytes.
module trivium_driver #(
  parameter int unsigned RDY_TMO = 1200
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  input  logic [79:0]        key_i,
  input  logic [79:0]        iv_i,
  input  logic               start_i,
  input  logic [7:0]         din_i,
  input  logic               din_valid_i,
  output logic               din_ready_o,
  output logic [7:0]         dout_o,
  output logic               dout_valid_o,
  output logic               busy_o,
  output logic               init_done_o,
  output logic               err_o,
  trivium_driver_if.master   core
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRE      = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_WAIT_RDY = 3'd3;
  localparam logic [2:0] S_READY    = 3'd4;
  localparam logic [2:0] S_BYTE     = 3'd5;
  localparam logic [2:0] S_TAIL     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam logic [10:0] TMO_END = 11'(RDY_TMO);

  logic [2:0]   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;       // load bit counter, reused as byte bit index
  logic [10:0]  tmo_q, tmo_d;       // cycles spent waiting for core ready
  logic [159:0] sr_q, sr_d;         // {iv, key}, shifted out LSB first
  logic [7:0]   byte_q, byte_d;     // plaintext byte, shifted out LSB first
  logic [6:0]   acc_q, acc_d;       // cipher bits 0..6 of the byte in flight
  logic [7:0]   dout_q, dout_d;
  logic         dvalid_q, dvalid_d;

  logic         dat_s;
  logic         get_s;
  logic         ld_s;
  logic         drdy_s;

  // Next-state and core-side output decode for the load/stream sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    sr_d     = sr_q;
    byte_d   = byte_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    dat_s    = 1'b0;
    get_s    = 1'b0;
    ld_s     = 1'b0;
    drdy_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sr_d    = {iv_i, key_i};
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PRE: begin
        get_s   = 1'b1;
        cnt_d   = 8'd0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        dat_s = sr_q[0];
        sr_d  = {1'b0, sr_q[159:1]};
        if (cnt_q == 8'd159) begin
          // Last IV bit: tell the core the load is complete.
          ld_s    = 1'b1;
          tmo_d   = 11'd0;
          state_d = S_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WAIT_RDY: begin
        if (core.core_ready_i) begin
          state_d = S_READY;
        end else if ((tmo_q + 11'd1) == TMO_END) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 11'd1;
        end
      end

      S_READY: begin
        drdy_s = 1'b1;
        if (din_valid_i) begin
          // Lead cycle: core is clocked once with a zero bit before the byte.
          get_s   = 1'b1;
          byte_d  = din_i;
          cnt_d   = 8'd0;
          state_d = S_BYTE;
        end else begin
          state_d = S_READY;
        end
      end

      S_BYTE: begin
        get_s  = 1'b1;
        dat_s  = byte_q[0];
        byte_d = {1'b0, byte_q[7:1]};
        acc_d  = {core.core_dat_i, acc_q[6:1]};
        if (cnt_q[2:0] == 3'd7) begin
          dout_d   = {core.core_dat_i, acc_q};
          dvalid_d = 1'b1;
          drdy_s   = 1'b1;
          if (din_valid_i) begin
            // Back-to-back byte: no lead or tail cycle between bytes.
            byte_d = din_i;
            cnt_d  = 8'd0;
          end else begin
            state_d = S_TAIL;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_TAIL: begin
        // Core is clocked with get_dat low; its output bit is dropped.
        state_d = S_READY;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and data registers; reset clears everything at once.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      tmo_q    <= 11'd0;
      sr_q     <= 160'd0;
      byte_q   <= 8'd0;
      acc_q    <= 7'd0;
      dout_q   <= 8'd0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      sr_q     <= sr_d;
      byte_q   <= byte_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign core.core_dat_o     = dat_s;
  assign core.core_get_dat_o = get_s;
  assign core.core_ld_keys_o = ld_s;

  assign din_ready_o  = drdy_s;
  assign dout_o       = dout_q;
  assign dout_valid_o = dvalid_q;

  assign busy_o      = (state_q == S_PRE)  || (state_q == S_SHIFT) ||
                       (state_q == S_WAIT_RDY) || (state_q == S_BYTE) ||
                       (state_q == S_TAIL);
  assign init_done_o = (state_q == S_READY) || (state_q == S_BYTE) ||
                       (state_q == S_TAIL);
  assign err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_trivium_driver.sv
// Directed/randomised bench for trivium_driver with a behavioural core model:
// the core returns (input bit XOR keystream bit) with zero latency.
module tb_trivium_driver;
  localparam int unsigned TMO = 1200;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [79:0] key = 80'd0;
  logic [79:0] iv = 80'd0;
  logic        start = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        busy;
  logic        init_done;
  logic        err;
  logic        ks_bit = 1'b0;
  logic        core_rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] bb [4];
  logic [7:0] kk [4];

  trivium_driver_if core_if ();

  assign core_if.core_dat_i   = core_if.core_dat_o ^ ks_bit;
  assign core_if.core_ready_i = core_rdy;

  trivium_driver #(.RDY_TMO(TMO)) dut (
    .clk_i        (clk),
    .n_rst_i      (n_rst),
    .key_i        (key),
    .iv_i         (iv),
    .start_i      (start),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_ready_o  (din_ready),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .busy_o       (busy),
    .init_done_o  (init_done),
    .err_o        (err),
    .core         (core_if)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Apply inputs for the current cycle and move to the sampling point.
  task automatic drive(input logic st, input logic dv, input logic [7:0] d,
                       input logic ksb, input logic rdy);
    start = st; din_valid = dv; din = d; ks_bit = ksb; core_rdy = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string t, input logic e_busy, input logic e_drdy,
                          input logic e_get, input logic e_dat, input logic e_ld,
                          input logic e_idone, input logic e_err);
    chk1({t, ".busy"}, busy, e_busy);
    chk1({t, ".din_ready"}, din_ready, e_drdy);
    chk1({t, ".get_dat"}, core_if.core_get_dat_o, e_get);
    chk1({t, ".core_dat"}, core_if.core_dat_o, e_dat);
    chk1({t, ".ld_keys"}, core_if.core_ld_keys_o, e_ld);
    chk1({t, ".init_done"}, init_done, e_idone);
    chk1({t, ".err"}, err, e_err);
  endtask

  task automatic chk_all_zero(input string t);
    chk_outs(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk8({t, ".dout"}, dout, 8'h00);
    chk1({t, ".dout_valid"}, dout_valid, 1'b0);
  endtask

  // Start cycle, PRE cycle and the first 'upto' SHIFT cycles of a key load.
  task automatic do_init(input logic [79:0] k, input logic [79:0] v, input int upto);
    logic eb;
    key = k; iv = v;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    key = ~k; iv = ~v;  // latched copy must be used from here on
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_outs("pre", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    for (int i = 0; i < upto; i++) begin
      eb = (i < 80) ? k[i] : v[i - 80];
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'b0);
      chk_outs($sformatf("shift%0d", i), 1'b1, 1'b0, 1'b0, eb, (i == 159), 1'b0, 1'b0);
      adv();
    end
  endtask

  // WAIT_RDY with the core raising ready 'lat' cycles after ld_keys.
  task automatic wait_ready(input int lat);
    for (int c = 1; c <= lat; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            1'b0, (c == lat));
      chk_outs("wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      adv();
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_outs("ready", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    adv();
  endtask

  // Stream n bytes bb[0..n-1] with keystream bytes kk[0..n-1].
  task automatic burst(input int n);
    logic dvn;
    logic [7:0] exp;
    drive(1'b0, 1'b1, bb[0], 1'b0, 1'b0);
    chk_outs("lead", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    adv();
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < 8; b++) begin
        dvn = (b == 7) && (j < n - 1);
        drive(1'b0, dvn, dvn ? bb[(j + 1) % 4] : 8'($urandom), kk[j][b], 1'b0);
        chk_outs($sformatf("byte%0d.bit%0d", j, b), 1'b1, (b == 7), 1'b1,
                 bb[j][b], 1'b0, 1'b1, 1'b0);
        chk1("dout_valid.in_byte", dout_valid, (b == 0) && (j > 0));
        if ((b == 0) && (j > 0)) begin
          exp = bb[j - 1] ^ kk[j - 1];
          chk8($sformatf("dout.byte%0d", j - 1), dout, exp);
        end
        adv();
      end
    end
    exp = bb[n - 1] ^ kk[n - 1];
    drive(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
    chk_outs("tail", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("tail.dout_valid", dout_valid, 1'b1);
    chk8("tail.dout", dout, exp);
    adv();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_outs("post", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("post.dout_valid", dout_valid, 1'b0);
    chk8("post.dout_hold", dout, exp);
    adv();
  endtask

  initial begin
    int n;
    logic [79:0] k2, v2, k3, v3;

    // Reset state, with noise on the inputs.
    start = 1'b1; din_valid = 1'b1; core_rdy = 1'b1;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Directed load: key = 1, iv = 0, start in the first cycle after reset.
    do_init(80'h0000_0000_0000_0000_0001, 80'h0, 160);
    wait_ready(1154);

    // Single byte A5 with all-ones keystream -> 5A.
    bb[0] = 8'hA5; kk[0] = 8'hFF;
    burst(1);

    // Back-to-back 00, FF.
    bb[0] = 8'h00; bb[1] = 8'hFF; kk[0] = 8'hFF; kk[1] = 8'hFF;
    burst(2);

    // Random bursts with random keystream.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < 4; j++) begin
        bb[j] = 8'($urandom);
        kk[j] = 8'($urandom);
      end
      burst(n);
    end

    // Asynchronous reset in the middle of a byte.
    drive(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
    adv();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk1("midbyte.busy", busy, 1'b1);
    #1 n_rst = 1'b0;
    #1 chk_all_zero("rst_byte");
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Asynchronous reset at SHIFT cycle 80.
    k2 = {16'($urandom), 32'($urandom), 32'($urandom)};
    v2 = {16'($urandom), 32'($urandom), 32'($urandom)};
    do_init(k2, v2, 80);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk1("shift80.busy", busy, 1'b1);
    chk1("shift80.dat", core_if.core_dat_o, v2[0]);
    #1 n_rst = 1'b0;
    #1 chk_all_zero("rst_shift");
    @(posedge clk); #1;
    n_rst = 1'b1;

    // New key after release, then a core that never becomes ready.
    k3 = {16'($urandom), 32'($urandom), 32'($urandom)};
    v3 = {16'($urandom), 32'($urandom), 32'($urandom)};
    do_init(k3, v3, 160);
    for (int c = 1; c <= int'(TMO); c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
      chk1("tmo_wait.err", err, 1'b0);
      chk1("tmo_wait.busy", busy, 1'b1);
      adv();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      chk_outs("err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trivium_driver.md
TRIVIUM_DRIVER -- requirements
Module: trivium_driver

Interface
REQ-001 SHALL have ports: clk_i  in  1  system clock, rising edge.
REQ-002 SHALL have ports: n_rst_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: key_i  in  80  key; iv_i  in  80  IV; both sampled when start_i is accepted.
REQ-004 SHALL have ports: start_i  in  1  single-cycle request to load key/IV.
REQ-005 SHALL have ports: din_i  in  8  plaintext byte; din_valid_i  in  1; din_ready_o  out  1.
REQ-006 SHALL have ports: dout_o  out  8  cipher byte; dout_valid_o  out  1  one-cycle pulse.
REQ-007 SHALL have ports: busy_o  out  1; init_done_o  out  1; err_o  out  1  sticky timeout flag.
REQ-008 SHALL have core-side ports: core_dat_o, core_get_dat_o, core_ld_keys_o (out, 1 each); core_dat_i, core_ready_i (in, 1 each).
REQ-009 SHALL have parameter: RDY_TMO, default 1200, max cycles from core_ld_keys_o to core_ready_i.

Function
REQ-010 SHALL implement states IDLE, PRE, SHIFT, WAIT_RDY, READY, BYTE, TAIL, ERR.
REQ-011 IDLE: start_i=1 SHALL latch key_i/iv_i into a 160-bit shift register {iv,key} and go to PRE; start_i in any other state SHALL be ignored.
REQ-012 PRE (1 cycle): core_get_dat_o=1, core_dat_o=0; next SHIFT with bit counter=0.
REQ-013 SHIFT (exactly 160 cycles): core_dat_o SHALL be key[0]..key[79], then iv[0]..iv[79], one bit per cycle, with core_get_dat_o=0.
REQ-014 core_ld_keys_o SHALL be 1 only in the cycle carrying iv[79] (counter=159); next state WAIT_RDY.
REQ-015 WAIT_RDY: an 11-bit timeout counter SHALL count from 0; core_ready_i=1 -> READY; counter reaching RDY_TMO before that -> ERR.
REQ-016 ERR: err_o=1, all core outputs 0, din_ready_o=0; exit only by reset.
REQ-017 READY: init_done_o=1, din_ready_o=1; din_valid_i=1 SHALL capture din_i, drive core_get_dat_o=1 that cycle (lead cycle, core_dat_o=0, no capture), and go to BYTE with bit index 0.
REQ-018 BYTE: core_get_dat_o=1; core_dat_o=byte[idx], LSB first; core_dat_i SHALL be captured into dout bit idx the same cycle (zero-latency core output).
REQ-019 At idx=7, din_ready_o=1; if din_valid_i=1 the next byte SHALL be captured and BYTE continue at idx=0 without a lead or gap cycle; else go to TAIL.
REQ-020 dout_o/dout_valid_o SHALL update one cycle after each idx=7 cycle; dout_o holds until the next byte completes.
REQ-021 TAIL (1 cycle): core_get_dat_o=0, core_dat_o=0, core_dat_i discarded (one keystream bit consumed); next READY.
REQ-022 din_ready_o SHALL be 0 in all cases except REQ-017 and REQ-019.
REQ-023 busy_o SHALL be 1 in PRE, SHIFT, WAIT_RDY, BYTE, TAIL; 0 in IDLE, READY, ERR.
REQ-024 Rekey SHALL require reset; init_done_o remains 1 from READY onward until reset.

Reset
REQ-025 n_rst_i=0 SHALL immediately force IDLE, clear all counters and registers, and drive all outputs 0, including mid-SHIFT or mid-BYTE.
REQ-026 After reset release, the first action SHALL be possible in the first clock cycle.

Verification
REQ-027 key=80'h0000_0000_0000_0000_0001, iv=0, start -> 1 PRE cycle, then core_dat_o=1 in SHIFT cycle 0 and 0 in cycles 1..159; ld_keys only in cycle 159.
REQ-028 Core model asserts ready 1154 cycles after ld_keys -> init_done_o=1, err_o=0; model never asserts ready -> err_o=1 at cycle RDY_TMO, and start_i is then ignored.
REQ-029 Model keystream all-ones, din=8'hA5 single byte -> dout_o=8'h5A with one dout_valid_o pulse; timing is lead, 8 BYTE, then TAIL.
REQ-030 Bytes 8'h00, 8'hFF back-to-back with din_valid_i held -> 16 consecutive get_dat cycles, no TAIL between bytes, two dout_valid_o pulses 8 cycles apart.
REQ-031 Reset asserted at SHIFT cycle 80 -> all outputs 0 asynchronously; a new start_i after release begins from PRE with the new key.
REQ-032 start_i pulsed in READY, and din_valid_i asserted during WAIT_RDY -> no state change and no byte accepted until READY.
